matrix_dump_sequencer: RTL
==========================

// Module: matrix_dump_sequencer
// PURPOSE
//   Sequences the matrix file writer: walks an N x N result buffer in row-major order, reads each word,
//   presents value/i/j to the writer, pulses its start and waits for its done before advancing.
//   Sits between the result memory of the multiplier and the writer; top level issues go, sees done.
// PARAMETERS
//   N   8                 matrix dimension (N x N elements), N >= 2
//   DW  32                element width, matches writer value port
//   IW  $clog2(N)         row/column index width
//   AW  $clog2(N*N)       result-buffer address width
// PORTS
//   clk            in   1    system clock, rising edge
//   rst_n          in   1    asynchronous active-low reset
//   go             in   1    start a full dump; sampled only in IDLE
//   abort          in   1    synchronous cancel of a dump in progress
//   busy           out  1    high from the cycle after go until return to IDLE
//   done           out  1    one-cycle pulse after the last element is acknowledged
//   mem_rd_en      out  1    read strobe to the result buffer
//   mem_addr       out  AW   read address = i*N + j
//   mem_rdata      in   DW   read data, valid the cycle after mem_rd_en (sync read)
//   wr_value       out  DW   element value to writer, held stable until wr_done
//   wr_i           out  IW   row index to writer
//   wr_j           out  IW   column index to writer
//   wr_start       out  1    one-cycle start pulse to writer
//   wr_done        in   1    writer completion pulse
//   words_written  out  AW+1 count of elements acknowledged in the current/last dump
// BEHAVIOUR
//   Reset: state IDLE; busy, done, mem_rd_en, wr_start = 0; mem_addr, wr_value, wr_i, wr_j,
//     words_written = 0. Reset mid-dump drops everything immediately; no done pulse.
//   All outputs registered. States: IDLE -> ISSUE -> CAPTURE -> WAIT -> (ISSUE | FINISH) -> IDLE.
//   IDLE: go=1 -> clear i, j, words_written; busy<=1; -> ISSUE. go while busy is ignored.
//   ISSUE: mem_rd_en=1 for exactly one cycle, mem_addr=i*N+j -> CAPTURE.
//   CAPTURE: latch mem_rdata into wr_value, i/j into wr_i/wr_j; wr_start<=1 -> WAIT.
//   WAIT: wr_start high only first WAIT cycle; wr_value/wr_i/wr_j held. On wr_done:
//     words_written+1; if (i,j)==(N-1,N-1) -> FINISH else j+1, wrap j N-1->0 with i+1 -> ISSUE.
//   FINISH: done=1 one cycle, busy<=0 -> IDLE. words_written holds N*N until next go.
//   Per-element cost: 3 cycles + writer latency (wr_done earliest the cycle after wr_start).
//   wr_done outside WAIT is ignored (no count, no advance).
//   abort: in any non-IDLE state -> IDLE next edge, busy<=0, wr_start<=0, mem_rd_en<=0,
//     no done pulse; words_written keeps partial count. abort and wr_done same cycle: abort wins.
//   abort and go same cycle in IDLE: go ignored.
//   Index arithmetic: i, j never exceed N-1; address computed as {i,j} only when N is 2^k,
//     otherwise i*N+j; both must yield identical values.
// STRUCTURE
//   Shared package matmul_pkg: state enum encoding, default N/DW, IW/AW derived localparams.
//   Sub-module rc_index_counter: row/column counter with clear, step, wrap and last flag;
//     reused by the multiplier's own matrix walkers.
// TESTING
//   1. Reset, N=8, buffer holds value k at addr k, writer acks 2 cycles after start, go pulse
//      -> 64 wr_start pulses, wr_i/wr_j/wr_value = (k/8, k%8, k) in order, one done, words_written=64.
//   2. Writer acks same-cycle-next (latency 1) -> 4 cycles per element, total 256+2 cycles go->done.
//   3. go asserted again while busy at element 10 -> ignored; sequence and count unchanged.
//   4. abort during WAIT of element 20 (with coincident wr_done) -> IDLE next cycle, no done,
//      words_written=20; new go restarts at (0,0).
//   5. rst_n low mid-dump at element 33 -> all outputs 0 asynchronously, state IDLE, no done.
//   6. Spurious wr_done in IDLE and during ISSUE -> ignored; N=3 build: addresses 0..8, wrap j=2->0.

Source files
------------

// File: rtl/matrix_dump_sequencer_pkg.sv
// Shared types and defaults for the matrix dump sequencer and its index walker.
package matrix_dump_sequencer_pkg;

  localparam int DEF_N  = 8;
  localparam int DEF_DW = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_FINISH  = 3'd4
  } dump_state_e;

  function automatic bit is_pow2(input int n);
    return (n & (n - 1)) == 0;
  endfunction

endpackage

// File: rtl/matrix_dump_sequencer_if.sv
// Result-buffer read port plus writer handshake, bundled between sequencer and its peers.
interface matrix_dump_sequencer_if
  import matrix_dump_sequencer_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW
);
  localparam int IW = $clog2(N);
  localparam int AW = $clog2(N * N);

  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] wr_value;
  logic [IW-1:0] wr_i;
  logic [IW-1:0] wr_j;
  logic          wr_start;
  logic          wr_done;

  modport master (
    output mem_rd_en, mem_addr, wr_value, wr_i, wr_j, wr_start,
    input  mem_rdata, wr_done
  );

  modport slave (
    input  mem_rd_en, mem_addr, wr_value, wr_i, wr_j, wr_start,
    output mem_rdata, wr_done
  );

endinterface

// File: rtl/matrix_dump_sequencer_rc_index_counter.sv
// Row-major (i, j) walker over an N x N grid with clear, step, wrap and last-element flag.
module matrix_dump_sequencer_rc_index_counter
  import matrix_dump_sequencer_pkg::*;
#(
  parameter  int N  = DEF_N,
  localparam int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          step,
  output logic [IW-1:0] i,
  output logic [IW-1:0] j,
  output logic [IW-1:0] i_next,
  output logic [IW-1:0] j_next,
  output logic          last
);

  localparam logic [IW-1:0] MAX = IW'(N - 1);

  logic j_wrap;

  assign j_wrap = (j == MAX);
  assign last   = j_wrap && (i == MAX);

  // Look-ahead position lets the caller address the next element in the same edge it steps.
  always_comb begin
    i_next = i;
    j_next = j + 1'b1;
    if (j_wrap) begin
      j_next = '0;
      i_next = (i == MAX) ? '0 : i + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
    end else if (clr) begin
      i <= '0;
      j <= '0;
    end else if (step) begin
      i <= i_next;
      j <= j_next;
    end
  end

endmodule

// File: rtl/matrix_dump_sequencer.sv
// Walks the N x N result buffer row-major, handing each word with its (i, j) to the file writer.
module matrix_dump_sequencer
  import matrix_dump_sequencer_pkg::*;
#(
  parameter  int N  = DEF_N,
  parameter  int DW = DEF_DW,
  localparam int IW = $clog2(N),
  localparam int AW = $clog2(N * N)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     go,
  input  logic                     abort,
  output logic                     busy,
  output logic                     done,
  output logic [AW:0]              words_written,
  matrix_dump_sequencer_if.master  bus
);

  dump_state_e   state;
  logic          rd_en_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] value_q;
  logic [IW-1:0] wi_q;
  logic [IW-1:0] wj_q;
  logic          start_q;

  logic [IW-1:0] idx_i, idx_j, nxt_i, nxt_j;
  logic          idx_last;
  logic          start_dump;
  logic          ack;

  // Concatenation and multiply-add agree when N is a power of two; the cheaper form is used there.
  function automatic logic [AW-1:0] rc_addr(input logic [IW-1:0] ri, input logic [IW-1:0] rj);
    if (is_pow2(N)) return AW'({ri, rj});
    return AW'(ri) * AW'(N) + AW'(rj);
  endfunction

  assign start_dump = (state == ST_IDLE) && go && !abort;
  assign ack        = (state == ST_WAIT) && bus.wr_done && !abort;

  matrix_dump_sequencer_rc_index_counter #(.N(N)) u_idx (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start_dump),
    .step   (ack && !idx_last),
    .i      (idx_i),
    .j      (idx_j),
    .i_next (nxt_i),
    .j_next (nxt_j),
    .last   (idx_last)
  );

  // Read strobe and address are raised on entry to ISSUE so they are registered yet live in ISSUE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_en_q       <= 1'b0;
      start_q       <= 1'b0;
      addr_q        <= '0;
      value_q       <= '0;
      wi_q          <= '0;
      wj_q          <= '0;
      words_written <= '0;
    end else begin
      done    <= 1'b0;
      rd_en_q <= 1'b0;
      start_q <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start_dump) begin
            words_written <= '0;
            busy          <= 1'b1;
            rd_en_q       <= 1'b1;
            addr_q        <= '0;
            state         <= ST_ISSUE;
          end
          ST_ISSUE: state <= ST_CAPTURE;
          ST_CAPTURE: begin
            value_q <= bus.mem_rdata;
            wi_q    <= idx_i;
            wj_q    <= idx_j;
            start_q <= 1'b1;
            state   <= ST_WAIT;
          end
          ST_WAIT: if (ack) begin
            words_written <= words_written + 1'b1;
            if (idx_last) begin
              done  <= 1'b1;
              state <= ST_FINISH;
            end else begin
              rd_en_q <= 1'b1;
              addr_q  <= rc_addr(nxt_i, nxt_j);
              state   <= ST_ISSUE;
            end
          end
          ST_FINISH: begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.mem_rd_en = rd_en_q;
  assign bus.mem_addr  = addr_q;
  assign bus.wr_value  = value_q;
  assign bus.wr_i      = wi_q;
  assign bus.wr_j      = wj_q;
  assign bus.wr_start  = start_q;

endmodule
